// File: rtl/uart_tx_slave.sv
// -----------------------------------------------------------------------------
// uart_tx_slave
//
// Wishbone (WB4, classic single-cycle) slave UART transmitter. The CPU pushes
// bytes into a small transmit FIFO through the DATA register. A framing FSM
// pops them and serialises each one on `tx` as an 8N1 frame, LSB first, with
// DELAY_CLOCKS clocks per bit cell. Frames follow each other without idle gaps
// while the FIFO holds data.
//
// Register map (only ADR_I[0] is decoded):
//   0x0 DATA   (W) push DAT_I[7:0]; reads return 0
//   0x1 STATUS (R) [7:0] FIFO used count, [8] busy, [9] overflow (sticky,
//                  cleared by a STATUS read), [10] full; writes ignored
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit (8E1 framing).
//
// Parameters:
//   FREQUENCY     clock frequency in Hz
//   BAUD_RATE     line rate in bit/s
//   DELAY_CLOCKS  clocks per bit cell (>= 2)
//   DEPTH         FIFO entries, power of two, 2..128
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   CYC_I  in   Wishbone cycle
//   STB_I  in   Wishbone strobe
//   WE_I   in   1 = write
//   ADR_I  in   address, bit 0 decoded
//   DAT_I  in   write data, bits [7:0] used
//   DAT_O  out  read data, valid in the ACK_O cycle, 0 otherwise
//   ACK_O  out  single-cycle acknowledge
//   tx     out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_slave #(
  parameter int FREQUENCY    = 25000000,
  parameter int BAUD_RATE    = 115200,
  parameter int DELAY_CLOCKS = FREQUENCY / BAUD_RATE,
  parameter int DEPTH        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        tx
);

  localparam int PW = $clog2(DEPTH);   // pointer width
  localparam int CW = PW + 1;          // count width, holds 0..DEPTH

  localparam logic [31:0] DELAY_LAST = 32'(DELAY_CLOCKS - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          ack_q;
  logic [31:0]   dat_q,   dat_d;
  logic          ovf_q,   ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [2:0]    state_q, state_d;
  logic [31:0]   delay_q, delay_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;

  logic [7:0]    mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic bus_req;
  logic wr_data;
  logic rd_status;
  logic full;
  logic busy;
  logic push;
  logic pop;
  logic [31:0] status;

  // A request is taken only when ACK_O is low, so a held strobe produces one
  // acknowledge per access instead of a continuous stream.
  assign bus_req   = CYC_I & STB_I & ~ack_q;
  assign wr_data   = bus_req &  WE_I & ~ADR_I[0];
  assign rd_status = bus_req & ~WE_I &  ADR_I[0];

  // Full is taken from the registered count: a pop on the same edge does not
  // make room for a write that arrives while the FIFO is full.
  assign full = (count_q == COUNT_FULL);
  assign busy = (state_q != S_IDLE);
  assign push = wr_data & ~full;

  assign status = {21'd0, full, ovf_q, busy, 8'(count_q)};

  // Only bit 0 of the address and the low data byte are meaningful.
  logic unused_bits;
  assign unused_bits = ^{ADR_I[31:1], DAT_I[31:8]};

  // ---------------------------------------------------------------------------
  // Bus response, overflow flag and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    dat_d    = 32'd0;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (rd_status) begin
      dat_d = status;
    end

    // Clear on the STATUS read, but a drop on the same edge wins.
    if (rd_status) ovf_d = 1'b0;
    if (wr_data && full) ovf_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  logic       bit_end;
  logic [2:0] bit_next;

  assign bit_end  = (delay_q == DELAY_LAST);
  assign bit_next = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        delay_d = 32'd0;
        bit_d   = 3'd0;
        // The start bit is driven from the same edge that pops the byte, so
        // tx falls one clock after the write is acknowledged.
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          delay_d = 32'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          delay_d = delay_q + 32'd1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          delay_d = 32'd0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^shift_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_next;
            tx_d  = shift_q[bit_next];
          end
        end else begin
          delay_d = delay_q + 32'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          delay_d = 32'd0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          delay_d = delay_q + 32'd1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          delay_d = 32'd0;
          bit_d   = 3'd0;
          // Chain straight into the next start bit when data is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          delay_d = delay_q + 32'd1;
        end
      end

      default: begin
        delay_d = 32'd0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      delay_q  <= 32'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      ack_q    <= bus_req;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      delay_q  <= delay_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  // NOTE: the FIFO storage has no reset; clearing the pointers and count
  // already makes every entry unreachable, and an unreset array maps onto
  // plain RAM or flop arrays without reset routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= DAT_I[7:0];
  end

  assign ACK_O = ack_q;
  assign DAT_O = dat_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_slave.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_slave
//
// Self-checking bench for uart_tx_slave with FREQUENCY=1 MHz, BAUD_RATE=100 kHz
// (10 clocks per bit) and DEPTH=4. A line monitor decodes frames from `tx`
// independently of the DUT internals; scenario tasks compare decoded bytes,
// frame start times, register reads and the exact line waveform against
// values computed from the UART framing rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_slave;

  localparam int D     = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I = 1'b0;
  logic [31:0] ADR_I = 32'd0;
  logic [31:0] DAT_I = 32'd0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        tx;

  int n_vec  = 0;
  int n_fail = 0;

  uart_tx_slave #(
    .FREQUENCY(1000000),
    .BAUD_RATE(100000),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Line monitor: finds a falling edge, samples the middle of each bit cell.
  // ---------------------------------------------------------------------------
  logic [7:0] rx_q[$];
  int         start_q[$];
  bit         ok_q[$];

  bit         mon_busy = 1'b0;
  int         mon_n = 0;
  int         mon_start = 0;
  bit         mon_ok = 1'b1;
  logic [7:0] mon_byte = 8'd0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy  = 1'b1;
        mon_n     = 0;
        mon_start = cyc;
        mon_ok    = 1'b1;
      end
    end else begin
      mon_n++;
      if (mon_n % D == D / 2) begin
        if (mon_n / D == 0) begin
          if (tx !== 1'b0) mon_ok = 1'b0;
        end else if (mon_n / D <= 8) begin
          mon_byte[mon_n / D - 1] = tx;
        end else if (mon_n / D == FB - 1) begin
          if (tx !== 1'b1) mon_ok = 1'b0;
          rx_q.push_back(mon_byte);
          start_q.push_back(mon_start);
          ok_q.push_back(mon_ok);
          mon_busy = 1'b0;
        end else begin
          if (tx !== ^mon_byte) mon_ok = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks (return observations; scenario tasks do the comparing)
  // ---------------------------------------------------------------------------
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          output logic ack);
    @(posedge clk); #1;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = adr; DAT_I = dat;
    @(posedge clk); #1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ack = ACK_O;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat,
                         output logic ack);
    @(posedge clk); #1;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr;
    @(posedge clk); #1;
    CYC_I = 1'b0; STB_I = 1'b0;
    ack = ACK_O;
    dat = DAT_O;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic drain();
    repeat (2 * D) @(posedge clk);
    #1;
    rx_q.delete(); start_q.delete(); ok_q.delete();
  endtask

  // Compare decoded frames against an expected byte list.
  task automatic compare_rx(input string name, input logic [7:0] exp_q[$]);
    bit ok;
    wait_rx(exp_q.size(), exp_q.size() * FRAME + 4 * D, ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d frames, need %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i] || ok_q[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s frame %0d: got %02h framing_ok=%0b, need %02h framing_ok=1",
                 name, i, rx_q[i], ok_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d; logic a;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_vec++;
    if ({tx, ACK_O, DAT_O} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx=%b ack=%b dat=%h, need tx=1 ack=0 dat=0", tx, ACK_O, DAT_O);
    end
    rst = 1'b1;
    wb_read(32'h1, d, a);
    n_vec++;
    if (a !== 1'b1 || d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_status: got ack=%b status=%h, need ack=1 status=0", a, d);
    end
  endtask

  task automatic test_single();
    logic a;
    logic [7:0] b = 8'h55;
    logic exp_bit;
    int nbad = 0;
    wb_write(32'h0, {24'd0, b}, a);
    n_vec++;
    if (a !== 1'b1 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack: got ack=%b tx=%b, need ack=1 tx=1", a, tx);
    end
    for (int k = 0; k <= FRAME; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        n_vec++;
        if (ACK_O !== 1'b0) begin
          n_fail++;
          $display("FAIL single_ack_width: got ack=%b, need 0", ACK_O);
        end
      end
      if (k / D == 0)             exp_bit = 1'b0;
      else if (k / D <= 8)        exp_bit = b[k / D - 1];
      else if (k / D == FB - 1 || k >= FRAME) exp_bit = 1'b1;
      else                        exp_bit = ^b;
      if (tx !== exp_bit) nbad++;
      if (tx !== exp_bit && nbad <= 4)
        $display("FAIL single_wave clk %0d: got tx=%b, need %b", k, tx, exp_bit);
    end
    n_vec++;
    if (nbad != 0) n_fail++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic a; logic [31:0] d;
    logic [7:0] exp_q[$];
    exp_q = '{8'hA3, 8'h0F, 8'hFF};
    foreach (exp_q[i]) wb_write(32'h0, {24'd0, exp_q[i]}, a);
    wb_read(32'h1, d, a);
    n_vec++;
    if (d !== 32'h0000_0102) begin
      n_fail++;
      $display("FAIL b2b_status: got %h, need 00000102", d);
    end
    compare_rx("b2b", exp_q);
    for (int i = 1; i < start_q.size(); i++) begin
      n_vec++;
      if (start_q[i] - start_q[i-1] !== FRAME) begin
        n_fail++;
        $display("FAIL b2b_gap %0d: got %0d clocks between starts, need %0d",
                 i, start_q[i] - start_q[i-1], FRAME);
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    logic a; logic [31:0] d;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      wb_write(32'h0, {24'd0, b}, a);
      if (i < 5) exp_q.push_back(b);   // byte 0 starts the frame, 1..4 fill, 5 drops
    end
    wb_read(32'h1, d, a);
    n_vec++;
    if (d !== 32'h0000_0704) begin
      n_fail++;
      $display("FAIL ovf_status1: got %h, need 00000704", d);
    end
    wb_read(32'h1, d, a);
    n_vec++;
    if (d !== 32'h0000_0504) begin
      n_fail++;
      $display("FAIL ovf_status2: got %h, need 00000504", d);
    end
    compare_rx("ovf", exp_q);
    drain();
  endtask

  task automatic test_reset_mid();
    logic a; logic [31:0] d;
    logic [7:0] b = 8'($urandom) & 8'hF7;   // data bit 3 low so the reset edge is visible
    int nbad = 0;
    wb_write(32'h0, {24'd0, b}, a);
    repeat (46) @(posedge clk);
    #3;
    n_vec++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre: got tx=%b, need 0", tx);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1 || ACK_O !== 1'b0 || DAT_O !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got tx=%b ack=%b dat=%h, need 1 0 0", tx, ACK_O, DAT_O);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wb_read(32'h1, d, a);
    n_vec++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_status: got %h, need 0", d);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) nbad++;
    end
    n_vec++;
    if (nbad != 0 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got %0d low clocks, %0d frames, need 0 0", nbad, rx_q.size());
    end
    drain();
  endtask

  task automatic test_misc_access();
    logic a; logic [31:0] d;
    logic [7:0] exp_q[$];
    int nbad = 0;
    wb_write(32'h1, 32'h0000_00FF, a);
    n_vec++;
    if (a !== 1'b1) begin
      n_fail++;
      $display("FAIL status_write_ack: got %b, need 1", a);
    end
    wb_read(32'h0, d, a);
    n_vec++;
    if (a !== 1'b1 || d !== 32'd0) begin
      n_fail++;
      $display("FAIL data_read: got ack=%b dat=%h, need 1 0", a, d);
    end
    wb_read(32'h1, d, a);
    n_vec++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL misc_status: got %h, need 0", d);
    end
    for (int k = 0; k < 3 * D; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) nbad++;
    end
    n_vec++;
    if (nbad != 0) begin
      n_fail++;
      $display("FAIL misc_tx_quiet: got %0d low clocks, need 0", nbad);
    end
    exp_q.push_back(8'($urandom));
    wb_write(32'h4, {24'd0, exp_q[0]}, a);
    compare_rx("adr4", exp_q);
    drain();
  endtask

  task automatic test_random();
    logic a;
    logic [7:0] exp_q[$];
    int nb;
    for (int r = 0; r < 4; r++) begin
      exp_q.delete();
      nb = $urandom_range(1, DEPTH);
      for (int i = 0; i < nb; i++) begin
        exp_q.push_back(8'($urandom));
        wb_write(32'h0, {24'd0, exp_q[i]}, a);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      compare_rx("random", exp_q);
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_misc_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
